// File: rtl/lobovic_uart_pkg.sv
// Shared types and divider helpers for the LoboVIC UART blocks.
package lobovic_uart_pkg;

    localparam int unsigned OS = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

    // Rounded clocks-per-oversample-tick.
    function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + (baud * OS) / 2) / (baud * OS);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DefaultDiv  = uart_div(50_000_000, 115200);
    localparam int unsigned DefaultDivW = cnt_width(DefaultDiv);
    localparam int unsigned OsW         = cnt_width(OS);

endpackage

// File: rtl/lobovic_uart_tick.sv
// Oversample tick divider; held at zero while clear is high so the phase follows the start edge.
module lobovic_uart_tick
    import lobovic_uart_pkg::*;
#(
    parameter int unsigned Div = 27
) (
    input  logic clk_50M,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned     CntW    = cnt_width(Div);
    localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = !clear && (cnt_q == CntLast);
        cnt_d = cnt_q + CntW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lobovic_uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote, one-byte holding register
// with valid/ready handoff, framing-error and overrun pulses.
module lobovic_uart_rx
    import lobovic_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned OS     = 16
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       UART_RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned Div    = uart_div(CLK_HZ, BAUD);
    localparam int unsigned OsCntW = $clog2(OS);

    logic [1:0]        sync_q;
    logic              rxs;
    rx_state_e         state_q, state_d;
    logic [OsCntW-1:0] os_cnt_q, os_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [1:0]        samp_q, samp_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              fe_q, fe_d;
    logic              ov_q, ov_d;
    logic              tick, tick_clear, os_last, decide, maj, deliver, xfer;

    assign rxs = sync_q[1];

    assign tick_clear = (state_q == StIdle) || (state_q == StBreak);

    lobovic_uart_tick #(
        .Div(Div)
    ) u_tick (
        .clk_50M(clk_50M),
        .rst    (rst),
        .clear  (tick_clear),
        .tick   (tick)
    );

    // Samples land as os_cnt becomes 7 and 8; the vote completes with rxs as it becomes 9.
    assign os_last = (os_cnt_q == OsCntW'(OS - 1));
    assign decide  = tick && (os_cnt_q == OsCntW'(8));
    assign maj     = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs) | (samp_q[0] & rxs);
    assign xfer    = valid_q & rx_ready;

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        samp_d    = samp_q;
        shift_d   = shift_q;
        deliver   = 1'b0;
        fe_d      = 1'b0;

        if (tick) begin
            os_cnt_d = os_last ? '0 : os_cnt_q + OsCntW'(1);
            if ((os_cnt_q == OsCntW'(6)) || (os_cnt_q == OsCntW'(7))) begin
                samp_d = {samp_q[0], rxs};
            end
        end

        case (state_q)
            StIdle: begin
                if (!rxs) begin
                    state_d  = StStart;
                    os_cnt_d = '0;
                end
            end
            StStart: begin
                if (decide && maj) begin
                    state_d = StIdle;
                end else if (tick && os_last) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                end
            end
            StData: begin
                if (decide) begin
                    shift_d = {maj, shift_q[7:1]};
                end
                if (tick && os_last) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                // Leave mid-stop so a back-to-back start edge is caught.
                if (decide) begin
                    if (maj) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                if (rxs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ov_d    = 1'b0;
        if (deliver) begin
            if (!valid_q || xfer) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            state_q   <= StIdle;
            os_cnt_q  <= '0;
            bit_idx_q <= '0;
            samp_q    <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], UART_RX};
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_idx_q <= bit_idx_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = fe_q;
    assign overrun   = ov_q;

endmodule

// File: tb/tb_lobovic_uart_rx.sv
// Bench for lobovic_uart_rx: a serial line driver feeds bytes, a scoreboard queue holds the
// bytes expected at each valid/ready transfer, and a monitor pops and compares them.
module tb_lobovic_uart_rx;

    localparam int BitClks   = 432;
    localparam int FrameClks = 10 * BitClks;
    localparam int LatClks   = 9 * 432 + 9 * 27 + 3;

    logic       clk_50M  = 1'b0;
    logic       rst      = 1'b1;
    logic       UART_RX  = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    longint      xfer_cyc[$];
    longint      cyc = 0;
    int          fe_seen = 0, ov_seen = 0, vrise_seen = 0, vhigh_seen = 0;
    logic        valid_prev = 1'b0;

    lobovic_uart_rx dut (
        .clk_50M  (clk_50M),
        .rst      (rst),
        .UART_RX  (UART_RX),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #10 clk_50M = ~clk_50M;

    always @(posedge clk_50M) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        n_cmp++;
        if (act < exp - tol || act > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // Monitor samples a quarter period before each rising edge: a transfer happens at that edge.
    always @(negedge clk_50M) begin
        #5;
        if (!rst) begin
            if (frame_err) fe_seen++;
            if (overrun) ov_seen++;
            if (rx_valid) vhigh_seen++;
            if (rx_valid && !valid_prev) vrise_seen++;
            if (rx_valid && rx_ready) begin
                xfer_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%02h, expected no transfer", rx_data);
                end else begin
                    check("xfer_data", longint'(rx_data), longint'(exp_q.pop_front()));
                end
            end
        end
        valid_prev = rx_valid;
    end

    // Caller must be at a falling edge; returns at a falling edge.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bit_clks);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            UART_RX = frame[i];
            repeat (bit_clks) @(negedge clk_50M);
        end
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (rx_valid !== 1'b1 && n < budget) begin
            @(posedge clk_50M);
            #1;
            n++;
        end
    endtask

    task automatic rx_one(input logic [7:0] b, input int bit_clks, input string tag);
        int lat;
        rx_ready = 1'b0;
        fork
            send_byte(b, 1'b1, bit_clks);
            wait_valid(LatClks + 100, lat);
        join
        check_near({tag, "_latency"}, lat, LatClks, 1);
        check({tag, "_data"}, longint'(rx_data), longint'(b));
        exp_q.push_back(b);
        rx_ready = 1'b1;
        @(negedge clk_50M);
        rx_ready = 1'b0;
        check({tag, "_valid_cleared"}, longint'(rx_valid), 0);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int fe0, ov0, vr0, vh0;
        longint gap;
        logic [7:0] rb;
        int bc;

        repeat (5) @(negedge clk_50M);
        check("reset_rx_data", longint'(rx_data), 0);
        check("reset_rx_valid", longint'(rx_valid), 0);
        check("reset_frame_err", longint'(frame_err), 0);
        check("reset_overrun", longint'(overrun), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk_50M);

        // Single byte with latency.
        rx_one(8'h55, BitClks, "single");

        // Back-to-back frames, consumer always ready.
        fe0 = fe_seen; ov0 = ov_seen; vr0 = vrise_seen; vh0 = vhigh_seen;
        xfer_cyc.delete();
        rx_ready = 1'b1;
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        send_byte(8'hA3, 1'b1, BitClks);
        send_byte(8'h0F, 1'b1, BitClks);
        UART_RX = 1'b1;
        repeat (20) @(negedge clk_50M);
        check("b2b_valid_rises", vrise_seen - vr0, 2);
        check("b2b_valid_cycles", vhigh_seen - vh0, 2);
        check("b2b_xfers", xfer_cyc.size(), 2);
        gap = (xfer_cyc.size() >= 2) ? xfer_cyc[1] - xfer_cyc[0] : -1;
        check("b2b_spacing", gap, FrameClks);
        check("b2b_frame_err", fe_seen - fe0, 0);
        check("b2b_overrun", ov_seen - ov0, 0);

        // Glitch start bit.
        rx_ready = 1'b0;
        vr0 = vrise_seen; fe0 = fe_seen;
        UART_RX = 1'b0;
        repeat (5) @(negedge clk_50M);
        UART_RX = 1'b1;
        repeat (BitClks + 50) @(negedge clk_50M);
        check("glitch_no_valid", vrise_seen - vr0, 0);
        check("glitch_no_frame_err", fe_seen - fe0, 0);

        // Framing error then line break for three byte times.
        vr0 = vrise_seen; fe0 = fe_seen;
        send_byte(8'h3C, 1'b0, BitClks);
        UART_RX = 1'b0;
        repeat (3 * FrameClks) @(negedge clk_50M);
        UART_RX = 1'b1;
        repeat (20) @(negedge clk_50M);
        check("break_one_frame_err", fe_seen - fe0, 1);
        check("break_no_valid", vrise_seen - vr0, 0);
        rx_one(8'h81, BitClks, "after_break");

        // Overrun: second byte dropped while the first is held.
        rx_ready = 1'b0;
        ov0 = ov_seen;
        send_byte(8'h11, 1'b1, BitClks);
        send_byte(8'h22, 1'b1, BitClks);
        repeat (20) @(negedge clk_50M);
        check("overrun_data_kept", longint'(rx_data), 8'h11);
        check("overrun_valid_kept", longint'(rx_valid), 1);
        check("overrun_pulses", ov_seen - ov0, 1);
        // Ready on the exact deliver edge: 0x11 leaves as 0x33 loads.
        exp_q.push_back(8'h11);
        fork
            send_byte(8'h33, 1'b1, BitClks);
            begin
                repeat (LatClks - 1) @(posedge clk_50M);
                @(negedge clk_50M);
                rx_ready = 1'b1;
                @(negedge clk_50M);
                rx_ready = 1'b0;
            end
        join
        check("same_cycle_data", longint'(rx_data), 8'h33);
        check("same_cycle_valid", longint'(rx_valid), 1);
        check("same_cycle_no_overrun", ov_seen - ov0, 1);
        check("same_cycle_popped", exp_q.size(), 0);

        // Reset during bit 4 of 0xF0, held until the frame ends.
        fe0 = fe_seen; ov0 = ov_seen;
        fork
            send_byte(8'hF0, 1'b1, BitClks);
            begin
                repeat (5 * BitClks + 200) @(negedge clk_50M);
                rst = 1'b1;
                #1;
                check("midreset_rx_data", longint'(rx_data), 0);
                check("midreset_rx_valid", longint'(rx_valid), 0);
            end
        join
        rst = 1'b0;
        repeat (5) @(negedge clk_50M);
        check("postreset_rx_valid", longint'(rx_valid), 0);
        check("postreset_no_pulses", (fe_seen - fe0) + (ov_seen - ov0), 0);
        rx_one(8'h5A, BitClks, "after_reset");

        // Baud skew.
        rx_one(8'h5A, 445, "skew_plus3");
        rx_one(8'h5A, 419, "skew_minus3");

        // Random bytes, random small skew and gaps, consumer always ready.
        fe0 = fe_seen; ov0 = ov_seen;
        rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom);
            bc = 424 + int'($urandom_range(0, 16));
            exp_q.push_back(rb);
            send_byte(rb, 1'b1, bc);
            UART_RX = 1'b1;
            repeat ($urandom_range(0, 40)) @(negedge clk_50M);
        end
        for (int i = 0; i < 6000 && exp_q.size() != 0; i++) @(negedge clk_50M);
        check("random_drained", exp_q.size(), 0);
        check("random_no_frame_err", fe_seen - fe0, 0);
        check("random_no_overrun", ov_seen - ov0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
